// File: rtl/ddr_cmd_decode.sv
// DDR4 command front-end: samples the command/address pins each clock and emits
// one-cycle command strobes plus the captured address, tracking CKE power states.
module ddr_cmd_decode #(
  parameter int ADDR_W = 17,
  parameter int BG_W   = 2,
  parameter int BA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cke,
  input  logic              cs_n,
  input  logic              act_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [BG_W-1:0]   bg,
  input  logic [BA_W-1:0]   ba,
  output logic              act,
  output logic              rd,
  output logic              rda,
  output logic              wr,
  output logic              wra,
  output logic              pr,
  output logic              pra,
  output logic              refresh,  // REF strobe; "ref" is a reserved word
  output logic              srf,
  output logic              pd,
  output logic              pdx,
  output logic              ckeh,
  output logic              ckel,
  output logic              mrw,
  output logic              mrr,
  output logic              cfg,
  output logic [BG_W-1:0]   bg_q,
  output logic [BA_W-1:0]   ba_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic              mpr_mode,
  output logic              cmd_err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    NORMAL  = 2'd1,
    PDOWN   = 2'd2,
    SELFREF = 2'd3
  } state_t;

  state_t     state;
  logic       cke_q;
  logic       rise;
  logic       fall;
  logic       valid;
  logic       nop;
  logic [2:0] code;

  assign rise      = cke & ~cke_q;
  assign fall      = ~cke & cke_q;
  assign code      = {ras_n, cas_n, we_n};
  assign nop       = act_n & (code == 3'b111);
  assign valid     = ~cs_n & cke_q & (state == NORMAL);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      cke_q    <= 1'b0;
      act      <= 1'b0;
      rd       <= 1'b0;
      rda      <= 1'b0;
      wr       <= 1'b0;
      wra      <= 1'b0;
      pr       <= 1'b0;
      pra      <= 1'b0;
      refresh  <= 1'b0;
      srf      <= 1'b0;
      pd       <= 1'b0;
      pdx      <= 1'b0;
      ckeh     <= 1'b0;
      ckel     <= 1'b0;
      mrw      <= 1'b0;
      mrr      <= 1'b0;
      cfg      <= 1'b0;
      cmd_err  <= 1'b0;
      mpr_mode <= 1'b0;
      bg_q     <= '0;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      cke_q   <= cke;
      act     <= 1'b0;
      rd      <= 1'b0;
      rda     <= 1'b0;
      wr      <= 1'b0;
      wra     <= 1'b0;
      pr      <= 1'b0;
      pra     <= 1'b0;
      refresh <= 1'b0;
      srf     <= 1'b0;
      pd      <= 1'b0;
      pdx     <= 1'b0;
      ckeh    <= 1'b0;
      ckel    <= 1'b0;
      mrw     <= 1'b0;
      mrr     <= 1'b0;
      cfg     <= 1'b0;
      cmd_err <= 1'b0;

      if (valid) begin
        bg_q   <= bg;
        ba_q   <= ba;
        addr_q <= a;
      end

      case (state)
        INIT: begin
          if (cke) state <= NORMAL;
        end
        NORMAL: begin
          if (fall) begin
            ckel <= 1'b1;
            if (valid && act_n && code == 3'b001) begin
              srf   <= 1'b1;
              state <= SELFREF;
            end else begin
              // Any real command caught by the CKE fall is dropped and flagged.
              pd      <= 1'b1;
              cmd_err <= valid & ~nop;
              state   <= PDOWN;
            end
          end else if (valid) begin
            if (!act_n) begin
              act <= 1'b1;
            end else begin
              case (code)
                3'b000: begin
                  mrw <= 1'b1;
                  if (bg == '0 && ba == BA_W'(3)) mpr_mode <= a[2];
                end
                3'b001: refresh <= 1'b1;
                3'b010: if (a[10]) pra <= 1'b1; else pr <= 1'b1;
                3'b011: cmd_err <= 1'b1;
                3'b100: if (a[10]) wra <= 1'b1; else wr <= 1'b1;
                3'b101: begin
                  if (mpr_mode)   mrr <= 1'b1;
                  else if (a[10]) rda <= 1'b1;
                  else            rd  <= 1'b1;
                end
                3'b110: cfg <= 1'b1;
                3'b111: ;
              endcase
            end
          end
        end
        PDOWN: begin
          cmd_err <= ~cs_n & ~nop;
          if (rise) begin
            pdx   <= 1'b1;
            ckeh  <= 1'b1;
            state <= NORMAL;
          end
        end
        SELFREF: begin
          cmd_err <= ~cs_n & ~nop;
          if (rise) begin
            ckeh  <= 1'b1;
            state <= NORMAL;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_decode.sv
// Directed vector bench for ddr_cmd_decode: a command table replayed cycle by
// cycle, plus hand-written asynchronous reset sequences.
module tb_ddr_cmd_decode;
  localparam int ADDR_W = 17;
  localparam int BG_W   = 2;
  localparam int BA_W   = 2;

  localparam logic [1:0] ST_INIT = 2'd0, ST_NORM = 2'd1, ST_PDN = 2'd2, ST_SRF = 2'd3;

  // strobe bit order: act rd rda wr wra pr pra ref srf pd pdx ckeh ckel mrw mrr cfg
  localparam logic [15:0] S_ACT = 16'h8000, S_RD = 16'h4000, S_RDA = 16'h2000,
    S_WR = 16'h1000, S_WRA = 16'h0800, S_PR = 16'h0400, S_PRA = 16'h0200,
    S_REF = 16'h0100, S_SRF = 16'h0080, S_PD = 16'h0040, S_PDX = 16'h0020,
    S_CKEH = 16'h0010, S_CKEL = 16'h0008, S_MRW = 16'h0004, S_MRR = 16'h0002,
    S_CFG = 16'h0001, S_NONE = 16'h0000;

  // {act_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_ACT = 4'b0111, C_MRS = 4'b1000, C_REF = 4'b1001,
    C_PRE = 4'b1010, C_RFU = 4'b1011, C_WR = 4'b1100, C_RD = 4'b1101,
    C_ZQ = 4'b1110, C_NOP = 4'b1111;

  typedef struct {
    logic              cke;
    logic              cs_n;
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] a;
    logic [BG_W-1:0]   bg;
    logic [BA_W-1:0]   ba;
    logic [15:0]       e_str;
    logic [BG_W-1:0]   e_bg;
    logic [BA_W-1:0]   e_ba;
    logic [ADDR_W-1:0] e_addr;
    logic              e_mpr;
    logic              e_err;
    logic [1:0]        e_st;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [ADDR_W-1:0] a;
  logic [BG_W-1:0]   bg;
  logic [BA_W-1:0]   ba;
  logic act, rd, rda, wr, wra, pr, pra, refresh, srf, pd, pdx, ckeh, ckel, mrw, mrr, cfg;
  logic [BG_W-1:0]   bg_q;
  logic [BA_W-1:0]   ba_q;
  logic [ADDR_W-1:0] addr_q;
  logic mpr_mode, cmd_err;
  logic [1:0] fsm_state;
  logic [15:0] str;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  assign str = {act, rd, rda, wr, wra, pr, pra, refresh, srf, pd, pdx, ckeh, ckel, mrw, mrr, cfg};

  always #5 clk = ~clk;

  ddr_cmd_decode #(.ADDR_W(ADDR_W), .BG_W(BG_W), .BA_W(BA_W)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .a(a), .bg(bg), .ba(ba),
    .act(act), .rd(rd), .rda(rda), .wr(wr), .wra(wra), .pr(pr), .pra(pra),
    .refresh(refresh), .srf(srf), .pd(pd), .pdx(pdx), .ckeh(ckeh), .ckel(ckel),
    .mrw(mrw), .mrr(mrr), .cfg(cfg), .bg_q(bg_q), .ba_q(ba_q), .addr_q(addr_q),
    .mpr_mode(mpr_mode), .cmd_err(cmd_err), .fsm_state(fsm_state)
  );

  function automatic vec_t v(logic k, logic cs, logic [3:0] cmd, logic [ADDR_W-1:0] aa,
                             logic [BG_W-1:0] g, logic [BA_W-1:0] b, logic [15:0] es,
                             logic [BG_W-1:0] eg, logic [BA_W-1:0] eb,
                             logic [ADDR_W-1:0] ea, logic em, logic ee, logic [1:0] est);
    vec_t r;
    r.cke = k; r.cs_n = cs; r.cmd = cmd; r.a = aa; r.bg = g; r.ba = b;
    r.e_str = es; r.e_bg = eg; r.e_ba = eb; r.e_addr = ea;
    r.e_mpr = em; r.e_err = ee; r.e_st = est;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act_v, exp_v);
    end
  endtask

  task automatic drive(logic k, logic cs, logic [3:0] cmd, logic [ADDR_W-1:0] aa,
                       logic [BG_W-1:0] g, logic [BA_W-1:0] b);
    cke = k; cs_n = cs; {act_n, ras_n, cas_n, we_n} = cmd; a = aa; bg = g; ba = b;
  endtask

  task automatic chk_all(int idx, logic [15:0] es, logic [BG_W-1:0] eg, logic [BA_W-1:0] eb,
                         logic [ADDR_W-1:0] ea, logic em, logic ee, logic [1:0] est);
    chk("strobes", idx, 32'(str), 32'(es));
    chk("bg_q", idx, 32'(bg_q), 32'(eg));
    chk("ba_q", idx, 32'(ba_q), 32'(eb));
    chk("addr_q", idx, 32'(addr_q), 32'(ea));
    chk("mpr_mode", idx, 32'(mpr_mode), 32'(em));
    chk("cmd_err", idx, 32'(cmd_err), 32'(ee));
    chk("fsm_state", idx, 32'(fsm_state), 32'(est));
  endtask

  initial begin
    // Outputs listed are those visible one cycle after the row's pins are sampled.
    tbl.push_back(v(0,1,C_NOP,17'h0,   0,0, S_NONE,        0,0,17'h0,   0,0,ST_INIT));
    tbl.push_back(v(1,1,C_NOP,17'h0,   0,0, S_NONE,        0,0,17'h0,   0,0,ST_NORM));
    tbl.push_back(v(1,0,C_ACT,17'h1234,1,2, S_ACT,         1,2,17'h1234,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_WR, 17'h0010,0,1, S_WR,          0,1,17'h0010,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_WR, 17'h0400,0,1, S_WRA,         0,1,17'h0400,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_RD, 17'h0020,2,0, S_RD,          2,0,17'h0020,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_RD, 17'h0420,2,0, S_RDA,         2,0,17'h0420,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_PRE,17'h0400,3,3, S_PRA,         3,3,17'h0400,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_PRE,17'h0000,1,1, S_PR,          1,1,17'h0000,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_MRS,17'h0004,0,3, S_MRW,         0,3,17'h0004,1,0,ST_NORM));
    tbl.push_back(v(1,0,C_RD, 17'h0008,1,0, S_MRR,         1,0,17'h0008,1,0,ST_NORM));
    tbl.push_back(v(1,0,C_RD, 17'h0408,1,0, S_MRR,         1,0,17'h0408,1,0,ST_NORM));
    tbl.push_back(v(1,0,C_MRS,17'h0000,1,3, S_MRW,         1,3,17'h0000,1,0,ST_NORM));
    tbl.push_back(v(1,0,C_MRS,17'h0000,0,3, S_MRW,         0,3,17'h0000,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_RD, 17'h0030,0,2, S_RD,          0,2,17'h0030,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_ZQ, 17'h0400,0,0, S_CFG,         0,0,17'h0400,0,0,ST_NORM));
    tbl.push_back(v(1,0,C_RFU,17'h0011,1,1, S_NONE,        1,1,17'h0011,0,1,ST_NORM));
    tbl.push_back(v(1,0,C_REF,17'h0000,0,0, S_REF,         0,0,17'h0000,0,0,ST_NORM));
    tbl.push_back(v(1,1,C_NOP,17'h0,   0,0, S_NONE,        0,0,17'h0000,0,0,ST_NORM));
    // self-refresh entry, ten cycles low with an ACT in the fifth, then exit
    tbl.push_back(v(0,0,C_REF,17'h0055,2,1, S_SRF|S_CKEL,  2,1,17'h0055,0,0,ST_SRF));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0,0,C_NOP,17'h0,0,0, S_NONE,         2,1,17'h0055,0,0,ST_SRF));
    tbl.push_back(v(0,0,C_ACT,17'h1111,3,3, S_NONE,        2,1,17'h0055,0,1,ST_SRF));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0,0,C_NOP,17'h0,0,0, S_NONE,         2,1,17'h0055,0,0,ST_SRF));
    tbl.push_back(v(1,0,C_NOP,17'h0,   0,0, S_CKEH,        2,1,17'h0055,0,0,ST_NORM));
    tbl.push_back(v(1,1,C_NOP,17'h0,   0,0, S_NONE,        2,1,17'h0055,0,0,ST_NORM));
    // power-down entry on NOP, an illegal command inside, exit four cycles later
    tbl.push_back(v(0,0,C_NOP,17'h0077,1,2, S_PD|S_CKEL,   1,2,17'h0077,0,0,ST_PDN));
    tbl.push_back(v(0,1,C_NOP,17'h0,   0,0, S_NONE,        1,2,17'h0077,0,0,ST_PDN));
    tbl.push_back(v(0,0,C_RFU,17'h0,   0,0, S_NONE,        1,2,17'h0077,0,1,ST_PDN));
    tbl.push_back(v(0,1,C_NOP,17'h0,   0,0, S_NONE,        1,2,17'h0077,0,0,ST_PDN));
    tbl.push_back(v(1,1,C_NOP,17'h0,   0,0, S_PDX|S_CKEH,  1,2,17'h0077,0,0,ST_NORM));
    // WR caught by the CKE fall is dropped
    tbl.push_back(v(0,0,C_WR, 17'h0099,3,0, S_PD|S_CKEL,   3,0,17'h0099,0,1,ST_PDN));
    tbl.push_back(v(1,1,C_NOP,17'h0,   0,0, S_PDX|S_CKEH,  3,0,17'h0099,0,0,ST_NORM));
    // enter power-down with MPR mode on, ahead of the async reset sequence
    tbl.push_back(v(1,0,C_MRS,17'h0004,0,3, S_MRW,         0,3,17'h0004,1,0,ST_NORM));
    tbl.push_back(v(0,1,C_NOP,17'h0,   0,0, S_PD|S_CKEL,   0,3,17'h0004,1,0,ST_PDN));

    // clock/reset
    rst = 1'b1;
    drive(0, 1, C_NOP, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, S_NONE, 0, 0, 17'h0, 0, 0, ST_INIT);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].cke, tbl[i].cs_n, tbl[i].cmd, tbl[i].a, tbl[i].bg, tbl[i].ba);
      @(posedge clk);
      #1;
      chk_all(i, tbl[i].e_str, tbl[i].e_bg, tbl[i].e_ba, tbl[i].e_addr,
              tbl[i].e_mpr, tbl[i].e_err, tbl[i].e_st);
    end

    // async reset mid-cycle while in PDOWN with mpr_mode set
    #2;
    rst = 1'b1;
    #1;
    chk_all(100, S_NONE, 0, 0, 17'h0, 0, 0, ST_INIT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1, C_NOP, '0, '0, '0);
    @(posedge clk);
    #1;
    chk_all(101, S_NONE, 0, 0, 17'h0, 0, 0, ST_INIT);
    drive(1, 1, C_NOP, '0, '0, '0);
    @(posedge clk);
    #1;
    chk_all(102, S_NONE, 0, 0, 17'h0, 0, 0, ST_NORM);
    // held high: no further ckeh
    @(posedge clk);
    #1;
    chk_all(103, S_NONE, 0, 0, 17'h0, 0, 0, ST_NORM);

    // async reset from SELFREF
    drive(0, 0, C_REF, 17'h0123, 1, 1);
    @(posedge clk);
    #1;
    chk_all(104, S_SRF|S_CKEL, 1, 1, 17'h0123, 0, 0, ST_SRF);
    #3;
    rst = 1'b1;
    #1;
    chk_all(105, S_NONE, 0, 0, 17'h0, 0, 0, ST_INIT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, C_ACT, 17'h0042, 2, 2);
    @(posedge clk);
    #1;
    chk_all(106, S_NONE, 0, 0, 17'h0, 0, 0, ST_NORM);
    @(posedge clk);
    #1;
    chk_all(107, S_ACT, 2, 2, 17'h0042, 0, 0, ST_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_decode.md
# ddr_cmd_decode

Front-end command decoder for the DRAM emulation path. Samples the raw DDR4 command/address pins every clock and produces the single-cycle command strobes consumed by the per-bank timing FSM: ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, CKEH, CKEL, MRW, MRR and CFG. It also registers the bank/row/column address. A small clock-enable state machine tracks power-down, self-refresh and MPR mode so that context-dependent commands decode correctly.

## Interface
Parameters:
- `ADDR_W`, 17, width of the row/column address bus `a`.
- `BG_W`, 2, bank-group address width.
- `BA_W`, 2, bank address width.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cke`  in  1  DRAM clock enable pin (level).
- `cs_n`, `act_n`, `ras_n`, `cas_n`, `we_n`  in  1 each  command pins, active-low.
- `a`  in  `ADDR_W`  address; `a[10]` is AP/all-banks, `a[2]` is the MPR bit.
- `bg`, `ba`  in  `BG_W` / `BA_W`  bank group and bank.
- `act`, `rd`, `rda`, `wr`, `wra`, `pr`, `pra`, `ref`, `srf`, `pd`, `pdx`, `ckeh`, `ckel`, `mrw`, `mrr`, `cfg`  out  1 each  one-cycle command strobes.
- `bg_q`, `ba_q`, `addr_q`  out  `BG_W` / `BA_W` / `ADDR_W`  address captured with the strobe.
- `mpr_mode`  out  1  MPR mode currently enabled.
- `cmd_err`  out  1  one-cycle flag for an illegal or ignored command.

## Operation
- Registers: `cke_q` holds the previous `cke`. Edge terms are `rise = cke & ~cke_q` and `fall = ~cke & cke_q`.
- A command is valid when `cs_n == 0`, `cke_q == 1` and the FSM is in NORMAL.
- Decode of valid commands:
  - `act_n == 0`: ACT.
  - Otherwise, by `{ras_n, cas_n, we_n}`:
    - 000: MRS. Raises `mrw`. If `bg == 0` and `ba == 3`, `mpr_mode <= a[2]`.
    - 001: REF. Raises `srf` instead of `ref` if `fall` occurs in the same cycle.
    - 010: PRE. Raises `pra` if `a[10]`, else `pr`.
    - 011: RFU. Raises `cmd_err` only.
    - 100: WR. Raises `wra` if `a[10]`, else `wr`.
    - 101: RD. If `mpr_mode`, raises `mrr` (never `rd`/`rda`). Otherwise `rda` if `a[10]`, else `rd`.
    - 110: ZQ calibration. Raises `cfg`.
    - 111: NOP, no strobe.
- At most one command strobe per cycle. `ckeh`, `ckel`, `pd` and `pdx` may coincide with each other as listed below.
- `bg_q`, `ba_q` and `addr_q` are loaded on every valid command and hold otherwise.
- FSM states:
  - INIT (reset state): all pins ignored and no strobes. On the first cycle with `cke == 1`, go to NORMAL. No `ckeh` is issued for that transition.
  - NORMAL:
    - REF with `fall`: `srf` and `ckel`, go to SELFREF.
    - Otherwise, `fall` with NOP/deselect: `pd` and `ckel`, go to PDOWN.
    - `fall` together with any other command: that command is dropped, `cmd_err` is raised, plus `pd` and `ckel`, go to PDOWN.
  - PDOWN: on `rise`, raise `pdx` and `ckeh`, go to NORMAL.
  - SELFREF: on `rise`, raise `ckeh`, go to NORMAL.
  - In PDOWN and SELFREF, `cs_n == 0` with a non-NOP code raises `cmd_err`, and the command is ignored.
- `mpr_mode` changes only on MRS to MR3. It is unaffected by power-down or self-refresh.

## Timing
- All outputs are registered. A strobe is high for exactly the one cycle after the pin sample that produced it.
- Latency is 1 clock from pin sample to strobe. Back-to-back commands produce back-to-back strobes with no bubble.
- The `mpr_mode` update from an MRS is visible to a RD sampled in the very next cycle.
- Reset values, applied asynchronously while `rst` is high:
  - All strobes, `cmd_err` and `mpr_mode` are 0.
  - `bg_q`, `ba_q` and `addr_q` are 0.
  - `cke_q` is 0 and the FSM is in INIT.
- Reset asserted mid-sequence (for example in SELFREF) clears everything on the same edge. After release the block requires `cke == 1` to leave INIT.
- `cke` held low for many cycles produces exactly one `ckel`. Held high, it produces exactly one `ckeh`.

## Test plan
- Reset, then `cke = 1` for 1 cycle, then ACT with `bg = 1`, `ba = 2`, `a = 0x1234`:
  - FSM goes INIT to NORMAL with no `ckeh`.
  - Next cycle `act = 1` for 1 cycle, `bg_q = 1`, `ba_q = 2`, `addr_q = 0x1234`.
- Back-to-back WR (`a[10] = 0`), WR (`a[10] = 1`), RD, RD (`a[10] = 1`), PRE (`a[10] = 1`) on consecutive cycles:
  - Strobes `wr`, `wra`, `rd`, `rda`, `pra` on 5 consecutive cycles, one each.
- MRS with `bg = 0`, `ba = 3`, `a[2] = 1`, next cycle RD:
  - `mrw`, then `mpr_mode = 1` and `mrr` with no `rd`.
  - MRS with `a[2] = 0`, then RD gives `rd`.
- REF with `cke` falling, hold `cke = 0` for 10 cycles with `cs_n = 0` plus ACT in cycle 5, then raise `cke`:
  - `srf` and `ckel` once.
  - `cmd_err` at cycle 5, no `act`.
  - `ckeh` once on exit.
- NOP with `cke` falling, then `cke` rising 4 cycles later:
  - `pd` + `ckel`, then `pdx` + `ckeh`, FSM back in NORMAL.
  - RFU code 011 raises `cmd_err` only.
- Assert `rst` asynchronously while in PDOWN with `mpr_mode = 1`:
  - All outputs 0 immediately, FSM in INIT.
  - A `cke` rise after release produces no `pdx`.
